// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers hex digits from a scanned 7-segment display and
// presents each complete set of digits as a frame on a valid/ready handshake.
module seg7_scan_decoder #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  frame_ready,
  output logic                  frame_valid,
  output logic [4*N_DIGITS-1:0] frame_data,
  output logic [N_DIGITS-1:0]   frame_err,
  output logic                  overrun
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [6:0]              seg_q, seg_p;
  logic [N_DIGITS-1:0]     en_q, en_p;
  logic [4*N_DIGITS-1:0]   work_data;
  logic [N_DIGITS-1:0]     work_err, captured, cap_mask;
  logic [3:0]              nib;
  logic                    ill, onehot, changed, cap, complete;
  always_comb begin
    nib = 4'h0;
    ill = 1'b0;
    case (seg_q)
      7'h7E: nib = 4'h0;
      7'h30: nib = 4'h1;
      7'h6D: nib = 4'h2;
      7'h79: nib = 4'h3;
      7'h33: nib = 4'h4;
      7'h5B: nib = 4'h5;
      7'h5F: nib = 4'h6;
      7'h70: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h73: nib = 4'h9;
      7'h7B: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h1F: nib = 4'hB;
      7'h4E: nib = 4'hC;
      7'h3D: nib = 4'hD;
      7'h4F: nib = 4'hE;
      7'h47: nib = 4'hF;
      default: ill = 1'b1;
    endcase
  end
  assign onehot   = $onehot(en_q);
  assign changed  = {seg_q, en_q} != {seg_p, en_p};
  assign complete = &captured;
  // Any change of the sampled pair restarts counting; DONE blocks recapture of a held pair.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    if (!onehot) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (state != DONE || changed) begin
      cnt_n   = (state == IDLE || changed) ? CW'(1) : cnt + CW'(1);
      cap     = cnt_n == CW'(STABLE_CYCLES);
      state_n = cap ? DONE : COUNT;
    end
  end
  assign cap_mask = cap ? en_q : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q     <= '0;
      en_q      <= '0;
      seg_p     <= '0;
      en_p      <= '0;
      state     <= IDLE;
      cnt       <= '0;
      work_data <= '0;
      work_err  <= '0;
      captured  <= '0;
    end else begin
      seg_q    <= seg_in;
      en_q     <= digit_en;
      seg_p    <= seg_q;
      en_p     <= en_q;
      state    <= state_n;
      cnt      <= cnt_n;
      captured <= (complete ? '0 : captured) | cap_mask;
      for (int k = 0; k < N_DIGITS; k++)
        if (cap_mask[k]) begin
          work_data[4*k+:4] <= nib;
          work_err[k]       <= ill;
        end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_err   <= '0;
      overrun     <= 1'b0;
    end else if (complete) begin
      frame_valid <= 1'b1;
      frame_data  <= work_data;
      frame_err   <= work_err;
      overrun     <= frame_valid && !frame_ready;
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: scoreboard bench; expected frames are queued as scans are
// driven and compared when the DUT hands a frame over.
module tb_seg7_scan_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = '0;
  logic [3:0]  digit_en = '0;
  logic        frame_ready = 1'b1;
  logic        frame_valid;
  logic [15:0] frame_data;
  logic [3:0]  frame_err;
  logic        overrun;
  int          checks = 0;
  int          failures = 0;
  typedef struct {logic [15:0] d; logic [3:0] e; logic o;} frame_t;
  frame_t      q[$];

  seg7_scan_decoder #(.N_DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit_en(digit_en),
    .frame_ready(frame_ready), .frame_valid(frame_valid), .frame_data(frame_data),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; holds the pattern for n full clock cycles.
  task automatic show(input logic [3:0] en, input logic [6:0] s, input int n);
    digit_en = en;
    seg_in   = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2, input logic [6:0] g3);
    show(4'b0001, g0, 5);
    show(4'b0010, g1, 5);
    show(4'b0100, g2, 5);
    show(4'b1000, g3, 5);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] e, input logic o);
    frame_t f;
    f.d = d;
    f.e = e;
    f.o = o;
    q.push_back(f);
  endtask

  always @(negedge clk)
    if (rst_n && frame_valid && frame_ready) begin
      if (q.size() == 0) chk("unexpected_frame", {16'h0, frame_data}, 32'hFFFFFFFF);
      else begin
        frame_t f;
        f = q.pop_front();
        chk("frame_data", frame_data, f.d);
        chk("frame_err", frame_err, f.e);
        chk("overrun", overrun, f.o);
      end
    end

  initial begin
    #1;
    chk("rst_valid", frame_valid, 0);
    chk("rst_data", frame_data, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // basic scan
    push(16'h0213, 4'h0, 1'b0);
    scan(7'h79, 7'h30, 7'h6D, 7'h7E);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("single_pulse", frame_valid, 0);
    // unstable digit 2 never captures
    show(4'b0001, 7'h30, 5);
    show(4'b0010, 7'h6D, 5);
    for (int i = 0; i < 5; i++) show(4'b0100, i[0] ? 7'h5F : 7'h5B, 2);
    chk("toggle_no_frame", frame_valid, 0);
    push(16'h0621, 4'h0, 1'b0);
    show(4'b0100, 7'h5F, 5);
    show(4'b1000, 7'h7E, 5);
    drain();
    // illegal blank glyph
    push(16'h4300, 4'b0010, 1'b0);
    scan(7'h7E, 7'h00, 7'h79, 7'h33);
    drain();
    // overrun with consumer stalled
    frame_ready = 1'b0;
    scan(7'h33, 7'h79, 7'h6D, 7'h30);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_valid1", frame_valid, 1);
    chk("stall_data1", frame_data, 16'h1234);
    chk("stall_ovr1", overrun, 0);
    scan(7'h7F, 7'h70, 7'h5F, 7'h5B);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_valid2", frame_valid, 1);
    chk("stall_data2", frame_data, 16'h5678);
    chk("stall_ovr2", overrun, 1);
    push(16'h5678, 4'h0, 1'b1);
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("accept_valid", frame_valid, 0);
    chk("accept_ovr", overrun, 0);
    chk("accept_q", q.size(), 0);
    // non-one-hot enable never captures
    show(4'b0011, 7'h7E, 10);
    show(4'b0000, 7'h7E, 5);
    show(4'b0010, 7'h30, 5);
    show(4'b0100, 7'h30, 5);
    show(4'b1000, 7'h30, 5);
    repeat (3) @(posedge clk);
    #1;
    chk("no_capture_0011", frame_valid, 0);
    // reset with three slots captured
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", frame_valid, 0);
    chk("mid_rst_data", frame_data, 0);
    chk("mid_rst_err", frame_err, 0);
    chk("mid_rst_ovr", overrun, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    show(4'b0001, 7'h7E, 6);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_partial", frame_valid, 0);
    push(16'hECA9, 4'h0, 1'b0);
    scan(7'h7B, 7'h77, 7'h4E, 7'h4F);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
